lv_abist_seq: RTL and testbench

- LV analog BIST sequencer; initiator side of the LV comparator self-test.
- On a start request it steps through N analog comparators (OV, UV, OT, …) one at a time:
  - asserts that comparator's force/request line;
  - times the comparator's response against a fixed window;
  - releases the force and waits a settle gap before the next item.
- Per-item pass bits and a summary fail flag go to the LV register file and safety FSM.
- Sits between the LV control FSM and the analog comparator force inputs.

---
 rtl/lv_abist_seq_pkg.sv | 23 ++
 rtl/lv_abist_seq_if.sv | 24 ++
 rtl/lv_abist_seq_tmr.sv | 25 ++
 rtl/lv_abist_seq.sv | 172 +++++++++++++++++
 tb/tb_lv_abist_seq.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/lv_abist_seq_pkg.sv
// rtl/lv_abist_seq_pkg.sv - shared types and timing helpers for the LV analog BIST sequencer
package lv_abist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FORCE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } bist_state_e;

  localparam int ITEM_OV = 0;
  localparam int ITEM_UV = 1;
  localparam int ITEM_OT = 2;

  function automatic int cyc_count(input int us, input int clk_m);
    return us * clk_m;
  endfunction

  function automatic int cnt_width(input int win, input int set);
    return $clog2(((win > set) ? win : set) + 1);
  endfunction

endpackage

// File: rtl/lv_abist_seq_if.sv
// rtl/lv_abist_seq_if.sv - control/result bundle between LV control FSM, sequencer and analog comparators
interface lv_abist_seq_if #(
  parameter int N = 3
);
  logic         i_bist_start;
  logic         i_bist_abort;
  logic [N-1:0] i_bist_en_mask;
  logic [N-1:0] i_ana_flag;
  logic [N-1:0] o_bist_req;
  logic         o_bist_busy;
  logic         o_bist_done;
  logic [N-1:0] o_bist_pass;
  logic         o_bist_fail;

  modport slave (
    input  i_bist_start, i_bist_abort, i_bist_en_mask, i_ana_flag,
    output o_bist_req, o_bist_busy, o_bist_done, o_bist_pass, o_bist_fail
  );

  modport master (
    output i_bist_start, i_bist_abort, i_bist_en_mask, i_ana_flag,
    input  o_bist_req, o_bist_busy, o_bist_done, o_bist_pass, o_bist_fail
  );
endinterface

// File: rtl/lv_abist_seq_tmr.sv
// rtl/lv_abist_seq_tmr.sv - saturating up-timer with clear and terminal count at a loadable limit
module lv_abist_tmr #(
  parameter int CW = 12
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [CW-1:0] i_lim,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc
);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != i_lim)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_lim);
endmodule

// File: rtl/lv_abist_seq.sv
// rtl/lv_abist_seq.sv - LV comparator self-test sequencer: force, time window, settle, per-item verdict
// Optional stuck-at-1 release check under LV_ABIST_SEQ_RELEASE_CHK_EN.
module lv_abist_seq
  import lv_abist_pkg::*;
#(
  parameter int CLK_M          = 48,
  parameter int BIST_ITEM_NUM  = 3,
  parameter int BIST_WIN_US    = 70,
  parameter int BIST_SETTLE_US = 10
) (
  input  logic           i_clk,
  input  logic           i_rst,
  lv_abist_seq_if.slave  s_bist
);
  localparam int N       = BIST_ITEM_NUM;
  localparam int WIN_CYC = cyc_count(BIST_WIN_US, CLK_M);
  localparam int SET_CYC = cyc_count(BIST_SETTLE_US, CLK_M);
  localparam int CW      = cnt_width(WIN_CYC, SET_CYC);
  localparam logic [CW-1:0] WIN_LIM  = CW'(WIN_CYC);
  localparam logic [CW-1:0] WIN_LAST = CW'(WIN_CYC - 1);
  localparam logic [CW-1:0] SET_LIM  = CW'(SET_CYC - 1);

  bist_state_e   r_state, w_state_nxt;
  logic [N-1:0]  r_mask, r_rem, r_pass, r_req;
  logic          r_fail, r_done;
  logic [N-1:0]  w_sel, w_rem_nxt, w_req_nxt;
  logic          w_flag, w_hit, w_rel_clr, w_pass_set, w_tmr_clr, w_tmr_en, w_tc;
  logic [CW-1:0] w_cnt, w_lim;

  function automatic logic [N-1:0] lowest_bit(input logic [N-1:0] m);
    return m & (~m + N'(1));
  endfunction

  assign w_sel     = lowest_bit(r_rem);
  assign w_rem_nxt = r_rem & ~w_sel;
  assign w_flag    = |(s_bist.i_ana_flag & w_sel);
  assign w_lim     = (r_state == ST_FORCE) ? WIN_LIM : SET_LIM;

  lv_abist_tmr #(.CW(CW)) u_tmr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_tmr_clr),
    .i_en  (w_tmr_en),
    .i_lim (w_lim),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );

`ifdef LV_ABIST_SEQ_RELEASE_CHK_EN
  // A flag already present when the force starts marks the comparator as stuck for this item.
  logic r_stuck;
  logic w_stuck_set;
  assign w_stuck_set = (r_state == ST_FORCE) && (w_cnt == '0) && w_flag;
  assign w_hit       = w_flag && !r_stuck && !w_stuck_set && !w_tc;
  assign w_rel_clr   = (r_state == ST_SETTLE) && w_tc && w_flag;

  always_ff @(posedge i_clk) begin
    if (i_rst || s_bist.i_bist_abort) begin
      r_stuck <= 1'b0;
    end else if ((r_state == ST_FORCE) && w_tc) begin
      r_stuck <= 1'b0;
    end else if (w_stuck_set) begin
      r_stuck <= 1'b1;
    end
  end
`else
  assign w_hit     = w_flag && !w_tc;
  assign w_rel_clr = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_clr   = 1'b0;
    w_tmr_en    = 1'b0;
    w_req_nxt   = '0;
    w_pass_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s_bist.i_bist_start) begin
          w_tmr_clr = 1'b1;
          if (|s_bist.i_bist_en_mask) begin
            w_state_nxt = ST_FORCE;
            w_req_nxt   = lowest_bit(s_bist.i_bist_en_mask);
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_FORCE: begin
        w_tmr_en = 1'b1;
        if (w_hit) begin
          w_pass_set  = 1'b1;
          w_state_nxt = ST_SETTLE;
          w_tmr_clr   = 1'b1;
        end else if (w_tc) begin
          w_state_nxt = ST_SETTLE;
          w_tmr_clr   = 1'b1;
        end else if (w_cnt != WIN_LAST) begin
          // Force drops once the window closes; the terminal cycle is a pure verdict cycle.
          w_req_nxt = w_sel;
        end
      end
      ST_SETTLE: begin
        w_tmr_en = 1'b1;
        if (w_tc) begin
          w_tmr_clr = 1'b1;
          if (|w_rem_nxt) begin
            w_state_nxt = ST_FORCE;
            w_req_nxt   = lowest_bit(w_rem_nxt);
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (s_bist.i_bist_abort) begin
      w_state_nxt = ST_IDLE;
      w_tmr_clr   = 1'b1;
      w_req_nxt   = '0;
      w_pass_set  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_rem   <= '0;
      r_pass  <= '0;
      r_req   <= '0;
      r_fail  <= 1'b0;
      r_done  <= 1'b0;
    end else if (s_bist.i_bist_abort) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_pass  <= '0;
      r_req   <= '0;
      r_fail  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_done  <= (r_state == ST_DONE);
      if ((r_state == ST_IDLE) && s_bist.i_bist_start) begin
        r_mask <= s_bist.i_bist_en_mask;
        r_rem  <= s_bist.i_bist_en_mask;
        r_pass <= '0;
        r_fail <= 1'b0;
      end
      if (w_pass_set) begin
        r_pass <= r_pass | w_sel;
      end
      if ((r_state == ST_SETTLE) && w_tc) begin
        r_rem <= w_rem_nxt;
        if (w_rel_clr) begin
          r_pass <= r_pass & ~w_sel;
        end
      end
      if (r_state == ST_DONE) begin
        r_fail <= |(r_mask & ~r_pass);
      end
    end
  end

  assign s_bist.o_bist_req  = r_req;
  assign s_bist.o_bist_busy = (r_state != ST_IDLE);
  assign s_bist.o_bist_done = r_done;
  assign s_bist.o_bist_pass = r_pass;
  assign s_bist.o_bist_fail = r_fail;
endmodule

// File: tb/tb_lv_abist_seq.sv
// tb/tb_lv_abist_seq.sv - directed and randomized checks of lv_abist_seq against a per-item timing model
module tb_lv_abist_seq;
  localparam int WIN = 70 * 48;
  localparam int SET = 10 * 48;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  lv_abist_seq_if #(.N(3)) bif ();

  lv_abist_seq #(
    .CLK_M(48), .BIST_ITEM_NUM(3), .BIST_WIN_US(70), .BIST_SETTLE_US(10)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .s_bist (bif)
  );

  always #5 clk = ~clk;

  // Comparator model: flag rises dly cycles after the force, drops with it unless held.
  int         dly[3] = '{99999, 99999, 99999};
  bit         hold = 1'b0;
  bit         noise_en = 1'b0;
  logic [2:0] run_mask = 3'b000;
  int         age[3] = '{0, 0, 0};
  logic [2:0] flg = 3'b000;
  logic [2:0] rsp_prev = 3'b000;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      if (bif.o_bist_req[i] === 1'b1) begin
        if (!rsp_prev[i]) age[i] = 0;
        else age[i] = age[i] + 1;
        if (age[i] >= dly[i]) flg[i] = 1'b1;
      end else if (!hold) begin
        flg[i] = 1'b0;
      end
      rsp_prev[i] = (bif.o_bist_req[i] === 1'b1);
    end
    bif.i_ana_flag = flg | (noise_en ? (3'($urandom) & ~run_mask) : 3'b000);
  end

  int         ord_q[$];
  int         dur_q[$];
  int         len[3] = '{0, 0, 0};
  int         done_cnt = 0;
  int         multi_hot = 0;
  logic [2:0] mon_prev = 3'b000;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (bif.o_bist_req[i] && !mon_prev[i]) begin
        ord_q.push_back(i);
        len[i] = 1;
      end else if (bif.o_bist_req[i]) begin
        len[i] = len[i] + 1;
      end else if (mon_prev[i]) begin
        dur_q.push_back(len[i]);
      end
    end
    if ($countones(bif.o_bist_req) > 1) multi_hot = multi_hot + 1;
    if (bif.o_bist_done === 1'b1) done_cnt = done_cnt + 1;
    mon_prev = bif.o_bist_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit item_hit(input int d);
`ifdef LV_ABIST_SEQ_RELEASE_CHK_EN
    return (d >= 1) && (d < WIN);
`else
    return d < WIN;
`endif
  endfunction

  function automatic bit item_pass(input int d, input bit hd);
`ifdef LV_ABIST_SEQ_RELEASE_CHK_EN
    return item_hit(d) && !hd;
`else
    return item_hit(d) && (hd || !hd);
`endif
  endfunction

  function automatic int req_len(input int d);
    return item_hit(d) ? d + 1 : WIN;
  endfunction

  function automatic int force_len(input int d);
    return item_hit(d) ? d + 1 : WIN + 1;
  endfunction

  function automatic int pick_dly();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return WIN - 1;
    if (r == 1) return WIN;
    return int'($urandom_range(1, 400));
  endfunction

  task automatic run(input logic [2:0] m, input int d0, input int d1, input int d2,
                     input bit hd, input bit nz);
    int         ob, db, dc, lat, exp_lat, k;
    logic [2:0] ep;
    dly[0] = d0; dly[1] = d1; dly[2] = d2;
    hold = hd; noise_en = nz; run_mask = m;
    ep = 3'b000;
    exp_lat = 2;
    for (int i = 0; i < 3; i++) begin
      if (m[i]) begin
        ep[i] = item_pass(dly[i], hd);
        exp_lat = exp_lat + force_len(dly[i]) + SET;
      end
    end
    ob = ord_q.size(); db = dur_q.size(); dc = done_cnt;
    @(negedge clk);
    bif.i_bist_start = 1'b1;
    bif.i_bist_en_mask = m;
    @(negedge clk);
    bif.i_bist_start = 1'b0;
    lat = 1;
    while (bif.o_bist_done !== 1'b1 && lat < exp_lat + 100) begin
      @(negedge clk);
      lat = lat + 1;
      bif.i_bist_start = (lat == 5) && bif.o_bist_busy;
      bif.i_bist_en_mask = ~m;
    end
    bif.i_bist_start = 1'b0;
    chk("done_latency", 32'(lat), 32'(exp_lat));
    chk("pass", 32'(bif.o_bist_pass), 32'(ep));
    chk("fail", 32'(bif.o_bist_fail), 32'(|(m & ~ep)));
    @(negedge clk);
    chk("busy_after_done", 32'(bif.o_bist_busy), 32'(0));
    chk("done_one_cycle", 32'(bif.o_bist_done), 32'(0));
    chk("done_count", 32'(done_cnt - dc), 32'(1));
    @(negedge clk);
    chk("pass_hold", 32'(bif.o_bist_pass), 32'(ep));
    chk("req_count", 32'(ord_q.size() - ob), 32'($countones(m)));
    k = 0;
    for (int i = 0; i < 3; i++) begin
      if (m[i] && (ob + k < ord_q.size()) && (db + k < dur_q.size())) begin
        chk("req_order", 32'(ord_q[ob + k]), 32'(i));
        chk("req_len", 32'(dur_q[db + k]), 32'(req_len(dly[i])));
        k = k + 1;
      end
    end
  endtask

  initial begin
    int         dc, lat;
    logic [2:0] m;
    int         rd[3];
    bif.i_bist_start = 1'b0;
    bif.i_bist_abort = 1'b0;
    bif.i_bist_en_mask = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(bif.o_bist_req), 32'(0));
    chk("rst_busy", 32'(bif.o_bist_busy), 32'(0));
    chk("rst_done", 32'(bif.o_bist_done), 32'(0));
    chk("rst_pass", 32'(bif.o_bist_pass), 32'(0));
    chk("rst_fail", 32'(bif.o_bist_fail), 32'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(3'b111, 100, 100, 100, 1'b0, 1'b0);
    run(3'b101, WIN - 1, 0, 99999, 1'b0, 1'b1);
    run(3'b001, WIN, 99999, 99999, 1'b0, 1'b0);

    // Abort while the UV item is being forced.
    dly[0] = 50; dly[1] = 99999; dly[2] = 99999;
    hold = 1'b0; noise_en = 1'b0; run_mask = 3'b111;
    dc = done_cnt;
    @(negedge clk);
    bif.i_bist_start = 1'b1;
    bif.i_bist_en_mask = 3'b111;
    @(negedge clk);
    bif.i_bist_start = 1'b0;
    lat = 1;
    while (bif.o_bist_req !== 3'b010 && lat < 2000) begin
      @(negedge clk);
      lat = lat + 1;
    end
    chk("abort_uv_forced", 32'(bif.o_bist_req), 32'(3'b010));
    repeat (10) @(negedge clk);
    chk("abort_ov_pass_before", 32'(bif.o_bist_pass), 32'(3'b001));
    bif.i_bist_abort = 1'b1;
    @(negedge clk);
    bif.i_bist_abort = 1'b0;
    chk("abort_req", 32'(bif.o_bist_req), 32'(0));
    chk("abort_pass", 32'(bif.o_bist_pass), 32'(0));
    chk("abort_fail", 32'(bif.o_bist_fail), 32'(0));
    chk("abort_busy", 32'(bif.o_bist_busy), 32'(0));
    repeat (20) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - dc), 32'(0));
    run(3'b111, 10, 20, 30, 1'b0, 1'b1);

    run(3'b000, 99999, 99999, 99999, 1'b0, 1'b1);

    run(3'b001, 100, 99999, 99999, 1'b1, 1'b0);
    hold = 1'b0;
    repeat (3) @(negedge clk);

    for (int r = 0; r < 4; r++) begin
      m = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) rd[i] = pick_dly();
      run(m, rd[0], rd[1], rd[2], 1'b0, 1'b1);
    end

    chk("req_one_hot", 32'(multi_hot), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
